// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Hazard and sequencing controller for the ID/EX/MEM/WB pipeline.
// Generates the execute-stage operand forwarding selects and the
// stall/flush enables for the F, D, E and M pipeline registers. It covers
// load-use hazards, taken branches and PC writes, and a long-op FSM that
// holds a multi-cycle instruction in E for LONG_LAT cycles. It also keeps
// a saturating count of StallF cycles for performance debug.
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   RA1D, RA2D               source registers of the instruction in D
//   RA1E, RA2E               source registers of the instruction in E
//   WA3E, WA3M, WA3W         destination registers in E, M, W
//   RegWriteE/M/W            the stage's instruction writes the register file
//   MemtoRegE                E instruction is a load
//   LongOpE                  E instruction is multi-cycle
//   BranchTakenE             branch resolved taken in E
//   PCWrPendingF             a PC write is in flight in D, E or M
//   PCSrcW                   W instruction writes PC (overrides everything)
//   CntClr                   synchronous clear of StallCount
//   ForwardAE, ForwardBE     00 register file, 01 ResultW, 10 ALUOutM
//   StallF/D/E               hold fetch PC, IF/ID, ID/EX
//   FlushD/E/M               clear IF/ID, ID/EX, EX/MEM
//   LongBusy                 long-op FSM is in BUSY
//   StallCount               saturating count of StallF cycles
//
// Long-op FSM states:
//   state | meaning
//   IDLE  | no long op in progress; a new LongOpE starts one
//   BUSY  | long op holding E; cnt = remaining stall cycles
module hazard_ctrl #(
    parameter int LONG_LAT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WA3E,
    input  logic [3:0]       WA3M,
    input  logic [3:0]       WA3W,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             LongOpE,
    input  logic             BranchTakenE,
    input  logic             PCWrPendingF,
    input  logic             PCSrcW,
    input  logic             CntClr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             LongBusy,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // The first long-op cycle is spent in IDLE, so BUSY only needs to
    // cover the remaining LONG_LAT-1 cycles, the last of which releases E.
    localparam logic [3:0] CNT_LOAD = 4'(LONG_LAT - 2);

    state_t     state;
    logic [3:0] cnt;
    logic       pc_flush;
    logic       ld_stall;
    logic       long_stall;

    // R15 reads return the PC, never a forwarded result.
    function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                           input logic [3:0] wa_m,
                                           input logic       rw_m,
                                           input logic [3:0] wa_w,
                                           input logic       rw_w);
        if (ra == 4'hF)
            fwd_sel = 2'b00;
        else if (rw_m && (ra == wa_m))
            fwd_sel = 2'b10;
        else if (rw_w && (ra == wa_w))
            fwd_sel = 2'b01;
        else
            fwd_sel = 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(RA1E, WA3M, RegWriteM, WA3W, RegWriteW);
    assign ForwardBE = fwd_sel(RA2E, WA3M, RegWriteM, WA3W, RegWriteW);

    assign pc_flush   = PCSrcW & ~reset;
    assign ld_stall   = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
    assign long_stall = ~pc_flush &
                        (((state == IDLE) & LongOpE) |
                         ((state == BUSY) & (cnt != 4'd0)));

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushM = 1'b0;
        if (pc_flush) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            StallF = ld_stall | PCWrPendingF | long_stall;
            StallD = ld_stall | long_stall;
            StallE = long_stall;
            // While E is held, flushing D/E would destroy the held instruction.
            FlushD = (PCWrPendingF | BranchTakenE) & ~long_stall;
            FlushE = (ld_stall | BranchTakenE) & ~long_stall;
            FlushM = long_stall;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else if (PCSrcW) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (LongOpE) begin
                        state <= BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    // Leaving at cnt==0 goes straight to IDLE without looking
                    // at LongOpE, which is still high for the departing op.
                    if (cnt == 4'd0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 4'd1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign LongBusy = (state == BUSY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            StallCount <= '0;
        else if (CntClr)
            StallCount <= '0;
        else if (StallF && (StallCount != '1))
            StallCount <= StallCount + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, LongOpE;
    logic        BranchTakenE, PCWrPendingF, PCSrcW, CntClr;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, LongBusy;
    logic [15:0] StallCount;

    int tests = 0;
    int fails = 0;

    hazard_ctrl #(.LONG_LAT(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .LongOpE(LongOpE), .BranchTakenE(BranchTakenE),
        .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW), .CntClr(CntClr),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .LongBusy(LongBusy), .StallCount(StallCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM}
    logic [9:0] outs;
    assign outs = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM};

    typedef struct {
        string      name;
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       rwe, rwm, rww, mtr, bt, pcwp, pcsrc;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name,
                                input logic [3:0] ra1d, input logic [3:0] ra2d,
                                input logic [3:0] ra1e, input logic [3:0] ra2e,
                                input logic [3:0] wa3e, input logic [3:0] wa3m,
                                input logic [3:0] wa3w,
                                input logic rwe, input logic rwm, input logic rww,
                                input logic mtr, input logic bt, input logic pcwp,
                                input logic pcsrc, input logic [9:0] exp);
        vec_t v;
        v.name = name; v.ra1d = ra1d; v.ra2d = ra2d; v.ra1e = ra1e; v.ra2e = ra2e;
        v.wa3e = wa3e; v.wa3m = wa3m; v.wa3w = wa3w;
        v.rwe = rwe; v.rwm = rwm; v.rww = rww; v.mtr = mtr; v.bt = bt;
        v.pcwp = pcwp; v.pcsrc = pcsrc; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0; WA3M = 0; WA3W = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; LongOpE = 0;
        BranchTakenE = 0; PCWrPendingF = 0; PCSrcW = 0; CntClr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #2;
        check("reset_longbusy", {31'd0, LongBusy}, 32'd0);
        check("reset_count", {16'd0, StallCount}, 32'd0);
        check("reset_outs", {22'd0, outs}, 32'd0);
        #10;
        reset = 1'b0;

        //            name            ra1d ra2d ra1e ra2e wa3e wa3m wa3w rwe rwm rww mtr bt pcwp pcsrc  exp
        vecs.push_back(mk("fwd_m",        0, 0, 3, 0, 0, 3, 3,  0,1,1, 0,0,0,0, {2'b10,2'b00,6'b000000}));
        vecs.push_back(mk("fwd_w",        0, 0, 3, 0, 0, 3, 3,  0,0,1, 0,0,0,0, {2'b01,2'b00,6'b000000}));
        vecs.push_back(mk("fwd_r15",      0, 0,15,15, 0,15,15,  0,1,1, 0,0,0,0, {2'b00,2'b00,6'b000000}));
        vecs.push_back(mk("fwd_b_m",      0, 0, 2, 7, 0, 7, 2,  0,1,1, 0,0,0,0, {2'b01,2'b10,6'b000000}));
        vecs.push_back(mk("fwd_w_nowr",   0, 0, 4, 4, 0, 0, 4,  0,0,0, 0,0,0,0, {2'b00,2'b00,6'b000000}));
        vecs.push_back(mk("lduse_rs2",    0, 5, 0, 0, 5, 0, 0,  1,0,0, 1,0,0,0, {2'b00,2'b00,6'b110010}));
        vecs.push_back(mk("lduse_none",   0, 6, 0, 0, 5, 0, 0,  1,0,0, 1,0,0,0, {2'b00,2'b00,6'b000000}));
        vecs.push_back(mk("lduse_rs1",    5, 0, 0, 0, 5, 0, 0,  1,0,0, 1,0,0,0, {2'b00,2'b00,6'b110010}));
        vecs.push_back(mk("load_nowr",    5, 0, 0, 0, 5, 0, 0,  0,0,0, 1,0,0,0, {2'b00,2'b00,6'b000000}));
        vecs.push_back(mk("branch",       0, 0, 0, 0, 0, 0, 0,  0,0,0, 0,1,0,0, {2'b00,2'b00,6'b000110}));
        vecs.push_back(mk("pcwr_pend",    0, 0, 0, 0, 0, 0, 0,  0,0,0, 0,0,1,0, {2'b00,2'b00,6'b100100}));
        vecs.push_back(mk("pcsrc_prio",   0, 5, 0, 0, 5, 0, 0,  1,0,0, 1,1,1,1, {2'b00,2'b00,6'b000110}));
        vecs.push_back(mk("ld_branch",    5, 0, 0, 0, 5, 0, 0,  1,0,0, 1,1,0,0, {2'b00,2'b00,6'b110110}));

        tick();
        foreach (vecs[i]) begin
            RA1D = vecs[i].ra1d; RA2D = vecs[i].ra2d; RA1E = vecs[i].ra1e; RA2E = vecs[i].ra2e;
            WA3E = vecs[i].wa3e; WA3M = vecs[i].wa3m; WA3W = vecs[i].wa3w;
            RegWriteE = vecs[i].rwe; RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            MemtoRegE = vecs[i].mtr; BranchTakenE = vecs[i].bt;
            PCWrPendingF = vecs[i].pcwp; PCSrcW = vecs[i].pcsrc;
            #1;
            check(vecs[i].name, {22'd0, outs}, {22'd0, vecs[i].exp});
            tick();
        end
        clear_inputs();

        // Long op, LONG_LAT=3: two stall cycles, third cycle releases E.
        CntClr = 1'b1;
        tick();
        CntClr = 1'b0;
        check("cnt_clr", {16'd0, StallCount}, 32'd0);
        LongOpE = 1'b1;
        #1;
        check("long_c1_outs", {22'd0, outs}, {22'd0, 2'b00, 2'b00, 6'b111001});
        check("long_c1_busy", {31'd0, LongBusy}, 32'd0);
        tick();
        check("long_c2_outs", {22'd0, outs}, {22'd0, 2'b00, 2'b00, 6'b111001});
        check("long_c2_busy", {31'd0, LongBusy}, 32'd1);
        tick();
        check("long_c3_outs", {22'd0, outs}, 32'd0);
        check("long_c3_busy", {31'd0, LongBusy}, 32'd1);
        tick();
        check("long_done_busy", {31'd0, LongBusy}, 32'd0);
        LongOpE = 1'b0;
        #1;
        check("long_count", {16'd0, StallCount}, 32'd2);

        // Abort by PCSrcW on the second long-op cycle.
        tick();
        LongOpE = 1'b1;
        tick();
        PCSrcW = 1'b1;
        #1;
        check("abort_outs", {22'd0, outs}, {22'd0, 2'b00, 2'b00, 6'b000110});
        check("abort_busy_now", {31'd0, LongBusy}, 32'd1);
        tick();
        PCSrcW = 1'b0;
        LongOpE = 1'b0;
        #1;
        check("abort_busy_next", {31'd0, LongBusy}, 32'd0);

        // Asynchronous reset while BUSY.
        tick();
        LongOpE = 1'b1;
        tick();
        check("pre_rst_busy", {31'd0, LongBusy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_busy", {31'd0, LongBusy}, 32'd0);
        check("rst_count", {16'd0, StallCount}, 32'd0);
        check("rst_idle_stall", {31'd0, StallE}, 32'd1);
        LongOpE = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Saturation and clear priority.
        CntClr = 1'b1;
        tick();
        CntClr = 1'b0;
        PCWrPendingF = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        check("cnt_fffe", {16'd0, StallCount}, 32'h0000_FFFE);
        repeat (3) @(posedge clk);
        #1;
        check("cnt_sat", {16'd0, StallCount}, 32'h0000_FFFF);
        CntClr = 1'b1;
        #1;
        check("clr_stallf", {31'd0, StallF}, 32'd1);
        tick();
        check("clr_prio", {16'd0, StallCount}, 32'd0);
        CntClr = 1'b0;
        tick();
        check("cnt_resume", {16'd0, StallCount}, 32'd1);
        PCWrPendingF = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Hazard and sequencing controller for the ID/EX/MEM/WB pipeline of the ARM core. Generates operand-forwarding selects for the execute stage and stall/flush enables for the F, D, E and M pipeline registers. It covers three cases: load-use hazards, taken branches and PC writes, and a multi-cycle execute FSM that holds an instruction in E for LONG_LAT cycles. It also keeps a saturating stall-cycle counter for performance debug.

Parameters:
LONG_LAT, 3, total cycles a long-op instruction (LongOpE=1) occupies E; legal range 2..15
CNT_W, 16, width of StallCount

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears FSM, down-counter and StallCount
RA1D  input  4  source register 1 of instruction in D
RA2D  input  4  source register 2 of instruction in D
RA1E  input  4  source register 1 of instruction in E
RA2E  input  4  source register 2 of instruction in E
WA3E  input  4  destination register of instruction in E
WA3M  input  4  destination register of instruction in M
WA3W  input  4  destination register of instruction in W
RegWriteE  input  1  E instruction writes register file
RegWriteM  input  1  M instruction writes register file
RegWriteW  input  1  W instruction writes register file
MemtoRegE  input  1  E instruction is a load
LongOpE  input  1  E instruction is multi-cycle; never asserted together with MemtoRegE
BranchTakenE  input  1  branch resolved taken in E
PCWrPendingF  input  1  a PC write is in flight in D, E or M
PCSrcW  input  1  instruction in W writes PC
CntClr  input  1  synchronous clear of StallCount
ForwardAE  output  2  SrcA select: 00 register file, 01 ResultW, 10 ALUOutM
ForwardBE  output  2  SrcB select, same encoding
StallF  output  1  hold fetch PC
StallD  output  1  hold IF/ID register
StallE  output  1  hold ID/EX register
FlushD  output  1  clear IF/ID register
FlushE  output  1  clear ID/EX register
FlushM  output  1  clear EX/MEM register (insert bubble)
LongBusy  output  1  FSM is not IDLE
StallCount  output  CNT_W  saturating count of cycles with StallF=1

Behaviour:
- Forwarding is purely combinational:
  - ForwardAE=10 if RegWriteM & RA1E==WA3M; else 01 if RegWriteW & RA1E==WA3W; else 00.
  - No forwarding when RA1E==4'hF (R15 read as PC).
  - ForwardBE is identical using RA2E.
- Load-use stall: LdrStall = MemtoRegE & RegWriteE & (RA1D==WA3E | RA2D==WA3E).
- Long-op FSM, states IDLE and BUSY, with a 4-bit down-counter cnt:
  - IDLE & LongOpE & !PCSrcW: go to BUSY, cnt <= LONG_LAT-2; LongStall=1 this cycle.
  - BUSY & cnt!=0: LongStall=1, cnt decrements.
  - BUSY & cnt==0: LongStall=0, E advances at this edge, go to IDLE. No retrigger from the still-high LongOpE.
  - Net effect: the instruction stays in E for exactly LONG_LAT cycles, with LONG_LAT-1 stall cycles.
- Outputs, with PCSrcW & !reset as top priority:
  - PCSrcW=1: FSM aborts to IDLE (cnt <= 0); FlushD=1, FlushE=1; StallF=StallD=StallE=0; FlushM=0.
  - Otherwise:
    - StallF = LdrStall | PCWrPendingF | LongStall
    - StallD = LdrStall | LongStall
    - StallE = LongStall
    - FlushD = PCWrPendingF | BranchTakenE, masked to 0 while LongStall
    - FlushE = LdrStall | BranchTakenE, masked to 0 while LongStall
    - FlushM = LongStall
- StallCount:
  - Increments each cycle StallF=1.
  - Saturates at all-ones.
  - CntClr has priority over increment and clears to 0.
- Reset (async, any cycle, including mid-BUSY): state IDLE, cnt 0, StallCount 0, LongBusy 0. Combinational outputs then follow IDLE-state equations.
- LongBusy = (state==BUSY); registered, so it is 0 in the first long-op cycle.

Test Plan:
- Forwarding: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. Set RA1E=15 -> 00.
- Load-use: MemtoRegE=1, RegWriteE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1, StallE=0, for 1 cycle. Change RA2D to 6 -> all deasserted.
- Long op, LONG_LAT=3: LongOpE=1 held -> StallF/D/E=1 and FlushM=1 for 2 cycles, 0 on 3rd. LongBusy=1 on cycles 2-3. StallCount advances by 2.
- Abort: PCSrcW=1 on 2nd cycle of long op -> FlushD=FlushE=1, stalls=0, next cycle LongBusy=0.
- Reset mid-BUSY: assert reset asynchronously -> LongBusy=0 and StallCount=0 immediately, without a clock edge.
- Counter: preload to 16'hFFFE via stalls, 3 more stall cycles -> 16'hFFFF held. CntClr=1 together with StallF=1 -> 0.
